multiword_add_seq: RTL and testbench

//   Multi-cycle sequencer that adds two N_WORDS*K-bit unsigned operands using one
//   K-bit ripple-carry slice, one slice per clock, least-significant word first.
//   The inter-word carry is held in a register. Sits between an operand producer and
//   a result consumer, with a valid/ready handshake on each side.

---
 rtl/add_pkg.sv | 19 +
 rtl/add_slice.sv | 26 ++
 rtl/multiword_add_seq.sv | 110 +++++++++++
 tb/tb_multiword_add_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the multi-word sequential adder: FSM encoding,
// default geometry, and the single-bit full-adder primitive.
package add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned K_DEF       = 8;
   localparam int unsigned N_WORDS_DEF = 4;

   // Returns {cout, sum} of one full-adder cell.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/add_slice.sv
// K-bit ripple-carry adder slice built from single-bit full adders,
// with carry-in and carry-out exposed for word chaining.
module add_slice
   import add_pkg::*;
#(
   parameter int unsigned K = K_DEF
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         cin,
   output logic [K-1:0] sum,
   output logic         cout
);

   logic cy;

   always_comb begin
      cy  = cin;
      sum = '0;
      for (int unsigned i = 0; i < K; i++) begin
         {cy, sum[i]} = full_add(a[i], b[i], cy);
      end
      cout = cy;
   end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential N_WORDS*K-bit adder: one shared K-bit slice processes one word
// per clock, LSW first, with the inter-word carry held in a register.
module multiword_add_seq
   import add_pkg::*;
#(
   parameter int unsigned K       = K_DEF,
   parameter int unsigned N_WORDS = N_WORDS_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_WORDS*K-1:0]   a,
   input  logic [N_WORDS*K-1:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N_WORDS*K-1:0]   sum,
   output logic                   carry_out,
   output logic                   busy
);

   localparam int unsigned W  = N_WORDS * K;
   localparam int unsigned IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [W-1:0]    a_reg, b_reg;
   logic [K-1:0]    sl_a, sl_b, sl_sum;
   logic            sl_cout;
   logic            last;
   logic            accept, consume;

   add_slice #(.K(K)) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_comb begin
      sl_a = a_reg[idx*K +: K];
      sl_b = b_reg[idx*K +: K];
      last = (idx == IW'(N_WORDS - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      consume   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            consume   = out_ready;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // idx is cleared on the last word so it never exceeds N_WORDS-1 for
   // non-power-of-two word counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         carry     <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         if (accept) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
            carry <= 1'b0;
         end
         if (state == RUN) begin
            sum[idx*K +: K] <= sl_sum;
            carry           <= sl_cout;
            if (last) begin
               idx       <= '0;
               carry_out <= sl_cout;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (4x8 and 1x8 geometries) with
// hand-computed expectations plus a randomized back-to-back run.
module tb_multiword_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, carry_out, busy;
   logic [31:0] a, b, sum;

   logic        iv1, ir1, ov1, or1, co1, bz1;
   logic [7:0]  a1, b1, s1;

   int tests = 0;
   int fails = 0;
   int n;
   int cyc = 0;
   int prev_acc;
   logic [32:0] exp33;

   always #5 clk = ~clk;

   multiword_add_seq #(.K(8), .N_WORDS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry_out(carry_out), .busy(busy)
   );

   multiword_add_seq #(.K(8), .N_WORDS(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1),
      .sum(s1), .carry_out(co1), .busy(bz1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_op(input logic [31:0] xa, input logic [31:0] xb);
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      check("ready_before_op", 64'(in_ready), 64'd1);
      a = xa;
      b = xb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      check("done_reached", 64'(out_valid), 64'd1);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
      #1 rst = 1'b1;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_carry_out", 64'(carry_out), 64'd0);
      // in_valid during reset must not start an operation
      in_valid = 1'b1; a = 32'h1; b = 32'h1;
      tick();
      check("rst_no_accept", 64'(busy), 64'd0);
      in_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      tick();

      // 1: low-word carry into word 1, latency 4
      out_ready = 1'b1;
      start_op(32'h000000FF, 32'h00000001);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_in_ready_low", 64'(in_ready), 64'd0);
      wait_done(n);
      check("t1_latency", 64'(n), 64'd4);
      check("t1_sum", 64'(sum), 64'h00000100);
      check("t1_cout", 64'(carry_out), 64'd0);
      tick();
      check("t1_consumed", 64'(out_valid), 64'd0);

      // 2: carry ripples through every word boundary
      start_op(32'hFFFFFFFF, 32'h00000001);
      wait_done(n);
      check("t2_sum", 64'(sum), 64'h00000000);
      check("t2_cout", 64'(carry_out), 64'd1);
      tick();

      // 3: backpressure holds result; in_valid ignored in DONE
      out_ready = 1'b0;
      start_op(32'h12345678, 32'h11111111);
      wait_done(n);
      for (int i = 0; i < 5; i++) begin
         check("t3_sum_hold", 64'(sum), 64'h23456789);
         check("t3_out_valid", 64'(out_valid), 64'd1);
         check("t3_in_ready", 64'(in_ready), 64'd0);
         a = 32'hDEAD0000 + 32'(i); b = 32'h0000BEEF;
         in_valid = (i % 2 == 0);
         tick();
      end
      in_valid = 1'b0;
      check("t3_sum_final", 64'(sum), 64'h23456789);
      check("t3_cout", 64'(carry_out), 64'd0);
      out_ready = 1'b1;
      tick();
      check("t3_released", 64'(out_valid), 64'd0);
      check("t3_no_extra_op", 64'(busy), 64'd0);
      check("t3_back_idle", 64'(in_ready), 64'd1);

      // 4: reset after two RUN cycles aborts
      start_op(32'h01020304, 32'h10101010);
      tick();
      tick();
      check("t4_partial_nonzero", 64'(sum != 0), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("t4_out_valid", 64'(out_valid), 64'd0);
      check("t4_busy", 64'(busy), 64'd0);
      check("t4_sum", 64'(sum), 64'd0);
      check("t4_cout", 64'(carry_out), 64'd0);
      check("t4_in_ready", 64'(in_ready), 64'd1);
      #3 rst = 1'b0;
      tick();
      start_op(32'hCAFEBABE, 32'h35014541);
      wait_done(n);
      check("t4_latency", 64'(n), 64'd4);
      check("t4_sum_after", 64'(sum), 64'hFFFFFFFF);
      check("t4_cout_after", 64'(carry_out), 64'd0);
      tick();

      // 6: single-word geometry
      or1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; iv1 = 1'b1;
      check("t6_ready", 64'(ir1), 64'd1);
      tick();
      iv1 = 1'b0;
      check("t6_run_not_valid", 64'(ov1), 64'd0);
      check("t6_busy", 64'(bz1), 64'd1);
      tick();
      check("t6_out_valid", 64'(ov1), 64'd1);
      check("t6_sum", 64'(s1), 64'h00);
      check("t6_cout", 64'(co1), 64'd1);
      tick();
      check("t6_consumed", 64'(ov1), 64'd0);

      // 5: in_valid held high, random operands and random out_ready
      prev_acc = -1;
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      for (int op = 0; op < 1000; op++) begin
         for (int i = 0; i < 20 && !in_ready; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
         end
         check("t5_ready", 64'(in_ready), 64'd1);
         exp33 = {1'b0, a} + {1'b0, b};
         tick();
         if (prev_acc >= 0) check("t5_spacing_ge6", 64'(cyc - prev_acc >= 6), 64'd1);
         prev_acc = cyc;
         a = $urandom; b = $urandom;
         n = 0;
         while (n < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) break;
            tick();
            n++;
         end
         check("t5_result", 64'({carry_out, sum}), 64'(exp33));
         tick();
      end
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
